// File: rtl/alarm_ctrl_if.sv
// Bundle of sensor, reprogramming, timer and status signals around the alarm controller.
// Ports: ignicao/door_driver/door_pass sensors, reprogram/time_param_sel/time_value bank write,
//        expired from the timer, tmr_start/tmr_interval to the timer, alarme/desarmar/state status.
interface alarm_ctrl_if;
    logic       ignicao;
    logic       door_driver;
    logic       door_pass;
    logic       reprogram;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       expired;
    logic       tmr_start;
    logic [3:0] tmr_interval;
    logic       alarme;
    logic       desarmar;
    logic [2:0] state;

    // Environment side: drives sensors, bank writes and the timer expiry flag.
    modport master (
        output ignicao, door_driver, door_pass, reprogram, time_param_sel, time_value, expired,
        input  tmr_start, tmr_interval, alarme, desarmar, state
    );

    // Controller side.
    modport slave (
        input  ignicao, door_driver, door_pass, reprogram, time_param_sel, time_value, expired,
        output tmr_start, tmr_interval, alarme, desarmar, state
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Anti-theft alarm control FSM: arms/triggers/sounds/disarms and sequences the shared timer.
// Latency: inputs sampled at an edge, new state and all outputs registered on that same edge.
// Ports: clock, reset (sync, active-high), bus (alarm_ctrl_if.slave) carrying sensors, bank writes,
//        timer handshake (tmr_start/tmr_interval/expired) and status (alarme/desarmar/state).
module alarm_ctrl #(
    parameter logic [3:0] T_ARM_DELAY       = 4'd6,
    parameter logic [3:0] T_DRIVER_DELAY    = 4'd8,
    parameter logic [3:0] T_PASSENGER_DELAY = 4'd15,
    parameter logic [3:0] T_ALARM_ON        = 4'd10
) (
    input  logic        clock,
    input  logic        reset,
    alarm_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ARMED         = 3'd0,
        TRIGGERED     = 3'd1,
        SOUND         = 3'd2,
        DISARMED      = 3'd3,
        DIS_IGN_OFF   = 3'd4,
        DIS_DOOR_OPEN = 3'd5,
        ARM_WAIT      = 3'd6
    } state_t;

    localparam logic [1:0] SEL_ARM   = 2'd0;
    localparam logic [1:0] SEL_DRV   = 2'd1;
    localparam logic [1:0] SEL_PASS  = 2'd2;
    localparam logic [1:0] SEL_ALARM = 2'd3;

    state_t     state_q;
    state_t     nxt;
    logic [3:0] param_q [4];
    logic       tmr_start_q;
    logic       blank_q;
    logic [3:0] ivl_q;
    logic       alarme_q;
    logic       desarmar_q;
    logic       start;
    logic [1:0] start_sel;
    logic       exp_ok;
    logic       any_door;

    // The timer may still be showing expiry from the previous phase for the
    // cycle of the restart pulse and the one after, so those samples are dropped.
    assign exp_ok   = bus.expired && !tmr_start_q && !blank_q;
    assign any_door = bus.door_driver || bus.door_pass;

    always_comb begin
        nxt       = state_q;
        start     = 1'b0;
        start_sel = SEL_ARM;
        case (state_q)
            ARMED: begin
                if (bus.ignicao) begin
                    nxt = DISARMED;
                end else if (bus.door_driver) begin
                    // Driver door wins when both doors open together.
                    nxt       = TRIGGERED;
                    start     = 1'b1;
                    start_sel = SEL_DRV;
                end else if (bus.door_pass) begin
                    nxt       = TRIGGERED;
                    start     = 1'b1;
                    start_sel = SEL_PASS;
                end
            end
            TRIGGERED: begin
                if (bus.ignicao) begin
                    nxt = DISARMED;
                end else if (exp_ok) begin
                    nxt       = SOUND;
                    start     = 1'b1;
                    start_sel = SEL_ALARM;
                end
            end
            SOUND: begin
                if (bus.ignicao) begin
                    nxt = DISARMED;
                end else if (exp_ok) begin
                    if (any_door) begin
                        start     = 1'b1;
                        start_sel = SEL_ALARM;
                    end else begin
                        nxt = ARMED;
                    end
                end
            end
            DISARMED: begin
                if (!bus.ignicao) nxt = DIS_IGN_OFF;
            end
            DIS_IGN_OFF: begin
                if (bus.ignicao)          nxt = DISARMED;
                else if (bus.door_driver) nxt = DIS_DOOR_OPEN;
            end
            DIS_DOOR_OPEN: begin
                if (bus.ignicao) begin
                    nxt = DISARMED;
                end else if (!bus.door_driver) begin
                    nxt       = ARM_WAIT;
                    start     = 1'b1;
                    start_sel = SEL_ARM;
                end
            end
            ARM_WAIT: begin
                // Reopening a door aborts arming without touching the timer.
                if (bus.ignicao)   nxt = DISARMED;
                else if (any_door) nxt = DIS_DOOR_OPEN;
                else if (exp_ok)   nxt = ARMED;
            end
            default: nxt = ARMED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ARMED;
            tmr_start_q <= 1'b0;
            blank_q     <= 1'b0;
            ivl_q       <= 4'd0;
            alarme_q    <= 1'b0;
            desarmar_q  <= 1'b0;
            param_q[0]  <= T_ARM_DELAY;
            param_q[1]  <= T_DRIVER_DELAY;
            param_q[2]  <= T_PASSENGER_DELAY;
            param_q[3]  <= T_ALARM_ON;
        end else begin
            state_q     <= nxt;
            tmr_start_q <= start;
            blank_q     <= tmr_start_q;
            // A same-edge write lands after this read, so the interval uses the old value.
            if (start) ivl_q <= param_q[start_sel];
            alarme_q    <= (nxt == SOUND);
            desarmar_q  <= (nxt == DISARMED) || (nxt == DIS_IGN_OFF) ||
                           (nxt == DIS_DOOR_OPEN) || (nxt == ARM_WAIT);
            if (bus.reprogram && (bus.time_value != 4'd0))
                param_q[bus.time_param_sel] <= bus.time_value;
        end
    end

    assign bus.state        = state_q;
    assign bus.tmr_start    = tmr_start_q;
    assign bus.tmr_interval = ivl_q;
    assign bus.alarme       = alarme_q;
    assign bus.desarmar     = desarmar_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed table-driven bench for alarm_ctrl plus hand-written priority sequences.
// Inputs are driven 1 time unit after the rising edge and outputs sampled at the same point.
// Ports: none (top-level bench).
module tb_alarm_ctrl;

    logic clock;
    logic reset;
    alarm_ctrl_if bus ();

    alarm_ctrl #(
        .T_ARM_DELAY      (4'd6),
        .T_DRIVER_DELAY   (4'd8),
        .T_PASSENGER_DELAY(4'd15),
        .T_ALARM_ON       (4'd10)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic       rst;
        logic       ign;
        logic       dd;
        logic       dp;
        logic       exp_in;
        logic       rep;
        logic [1:0] sel;
        logic [3:0] val;
        logic [2:0] e_state;
        logic       e_al;
        logic       e_des;
        logic       e_st;
        logic [3:0] e_iv;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    logic prev_st  = 1'b0;

    function automatic vec_t mk(input logic rst, ign, dd, dp, exp_in, rep,
                                input logic [1:0] sel, input logic [3:0] val,
                                input logic [2:0] es, input logic eal, edes, est,
                                input logic [3:0] eiv);
        vec_t v;
        v.rst = rst; v.ign = ign; v.dd = dd; v.dp = dp; v.exp_in = exp_in;
        v.rep = rep; v.sel = sel; v.val = val;
        v.e_state = es; v.e_al = eal; v.e_des = edes; v.e_st = est; v.e_iv = eiv;
        return v;
    endfunction

    // Drive one cycle of inputs, let one rising edge pass, then sample.
    task automatic step(input logic rst, ign, dd, dp, exp_in, rep,
                        input logic [1:0] sel, input logic [3:0] val);
        reset              = rst;
        bus.ignicao        = ign;
        bus.door_driver    = dd;
        bus.door_pass      = dp;
        bus.expired        = exp_in;
        bus.reprogram      = rep;
        bus.time_param_sel = sel;
        bus.time_value     = val;
        @(posedge clock);
        #1;
        if (bus.tmr_start) begin
            checks++;
            if (prev_st) begin
                failures++;
                $display("FAIL tmr_start_consecutive at t=%0t: actual two cycles high, required single pulse", $time);
            end
        end
        prev_st = bus.tmr_start;
    endtask

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual state=%0d al=%0b des=%0b st=%0b iv=%0d required state=%0d al=%0b des=%0b st=%0b iv=%0d",
                     name, act[10:8], act[7], act[6], act[5], act[4:0],
                     req[10:8], req[7], req[6], req[5], req[4:0]);
        end
    endtask

    function automatic logic [10:0] outs();
        return {bus.state, bus.alarme, bus.desarmar, bus.tmr_start, bus.tmr_interval};
    endfunction

    initial begin
        reset = 1'b1;
        bus.ignicao = 0; bus.door_driver = 0; bus.door_pass = 0; bus.expired = 0;
        bus.reprogram = 0; bus.time_param_sel = 0; bus.time_value = 0;
        #1;

        //              rst ign dd dp exp rep sel  val  | st al des st iv
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd0, 0, 0, 0, 4'd0));  // 0 reset
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2'd0, 4'd0,  3'd1, 0, 0, 1, 4'd15)); // 1 passenger trigger
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd1, 0, 0, 0, 4'd15));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd1, 0, 0, 0, 4'd15));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd0, 4'd0,  3'd2, 1, 0, 1, 4'd10)); // 4 sound
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd2, 1, 0, 0, 4'd10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd2, 1, 0, 0, 4'd10));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd0, 4'd0,  3'd0, 0, 0, 0, 4'd10)); // 7 rearm
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 2'd0, 4'd0,  3'd1, 0, 0, 1, 4'd8));  // 8 both doors
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd1, 0, 0, 0, 4'd8));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2'd0, 4'd0,  3'd1, 0, 0, 0, 4'd8));  // 10 door ignored
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd0, 4'd0,  3'd2, 1, 0, 1, 4'd10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd2, 1, 0, 0, 4'd10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd2, 1, 0, 0, 4'd10));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 2'd0, 4'd0,  3'd2, 1, 0, 1, 4'd10)); // 14 restart
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd2, 1, 0, 0, 4'd10));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 2'd0, 4'd0,  3'd3, 0, 1, 0, 4'd10)); // 16 ign beats exp
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd4, 0, 1, 0, 4'd10));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2'd0, 4'd0,  3'd5, 0, 1, 0, 4'd10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd6, 0, 1, 1, 4'd6));  // 19 arm wait
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2'd0, 4'd0,  3'd5, 0, 1, 0, 4'd6));  // 20 abort
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd6, 0, 1, 1, 4'd6));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd0, 4'd0,  3'd6, 0, 1, 0, 4'd6));  // 22 blanked
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd0, 4'd0,  3'd6, 0, 1, 0, 4'd6));  // 23 blanked
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd0, 4'd0,  3'd0, 0, 0, 0, 4'd6));  // 24 armed
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2'd1, 4'd3,  3'd0, 0, 0, 0, 4'd6));  // 25 write drv=3
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2'd0, 4'd0,  3'd1, 0, 0, 1, 4'd3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd1, 0, 0, 0, 4'd3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd1, 0, 0, 0, 4'd3));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd0, 4'd0,  3'd2, 1, 0, 1, 4'd10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd2, 1, 0, 0, 4'd10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd2, 1, 0, 0, 4'd10));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd0, 4'd0,  3'd0, 0, 0, 0, 4'd10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2'd1, 4'd0,  3'd0, 0, 0, 0, 4'd10)); // 33 zero write
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2'd0, 4'd0,  3'd1, 0, 0, 1, 4'd3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd1, 0, 0, 0, 4'd3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd1, 0, 0, 0, 4'd3));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 2'd3, 4'd5,  3'd2, 1, 0, 1, 4'd10)); // 37 write+start
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd2, 1, 0, 0, 4'd10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd2, 1, 0, 0, 4'd10));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 2'd0, 4'd0,  3'd2, 1, 0, 1, 4'd5));  // 40 new value
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd0, 4'd0,  3'd2, 1, 0, 0, 4'd5));  // 41 stale
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd0, 4'd0,  3'd2, 1, 0, 0, 4'd5));  // 42 stale
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd0, 4'd0,  3'd0, 0, 0, 0, 4'd5));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2'd0, 4'd0,  3'd1, 0, 0, 1, 4'd15));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd1, 0, 0, 0, 4'd15));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd1, 0, 0, 0, 4'd15));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd0, 4'd0,  3'd2, 1, 0, 1, 4'd5));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2'd0, 4'd0,  3'd0, 0, 0, 0, 4'd0));  // 48 reset in SOUND
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2'd0, 4'd0,  3'd1, 0, 0, 1, 4'd8));  // 49 default back
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 2'd0, 4'd0,  3'd3, 0, 1, 0, 4'd8));  // 50 ign in TRIG

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].ign, vecs[i].dd, vecs[i].dp, vecs[i].exp_in,
                 vecs[i].rep, vecs[i].sel, vecs[i].val);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].e_state, vecs[i].e_al, vecs[i].e_des, vecs[i].e_st, vecs[i].e_iv});
        end

        // Ignition priority over doors in every disarm-path state.
        step(1, 0, 0, 0, 0, 0, 2'd0, 4'd0);
        check("seq_reset", outs(), {3'd0, 1'b0, 1'b0, 1'b0, 4'd0});
        step(0, 1, 1, 1, 0, 0, 2'd0, 4'd0);
        check("seq_armed_ign_door", outs(), {3'd3, 1'b0, 1'b1, 1'b0, 4'd0});
        step(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
        check("seq_ign_off", outs(), {3'd4, 1'b0, 1'b1, 1'b0, 4'd0});
        step(0, 1, 1, 0, 0, 0, 2'd0, 4'd0);
        check("seq_igoff_ign_door", outs(), {3'd3, 1'b0, 1'b1, 1'b0, 4'd0});
        step(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
        step(0, 0, 1, 0, 0, 0, 2'd0, 4'd0);
        check("seq_door_open", outs(), {3'd5, 1'b0, 1'b1, 1'b0, 4'd0});
        step(0, 1, 0, 0, 0, 0, 2'd0, 4'd0);
        check("seq_dooropen_ign", outs(), {3'd3, 1'b0, 1'b1, 1'b0, 4'd0});
        step(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
        step(0, 0, 1, 0, 0, 0, 2'd0, 4'd0);
        step(0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
        check("seq_arm_wait", outs(), {3'd6, 1'b0, 1'b1, 1'b1, 4'd6});
        step(0, 1, 1, 0, 1, 0, 2'd0, 4'd0);
        check("seq_armwait_ign", outs(), {3'd3, 1'b0, 1'b1, 1'b0, 4'd6});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
